kong_controller: RTL and testbench

KONG_CONTROLLER -- requirements
Module: kong_controller

---
 rtl/kong_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_kong_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/kong_controller.sv
// Kong motion controller: walk/climb/jump state machine with gravity, wall blocking and screen clamping.
// Latency: all state advances on the startOfFrame cycle; outputs reflect the update one cycle later.
// Backpressure: none; inputs are sampled only on the startOfFrame cycle and outputs hold otherwise.

package kong_pkg;
  typedef logic signed [10:0] location;

  typedef enum logic [2:0] {
    KONG_IS_STANDING,
    KONG_IS_CLIMBING,
    KONG_IS_JUMPING,
    KONG_IS_JUMPING_IN_PLATFORM,
    KONG_IS_JUMPING_FROM_ROPE
  } kong_state;

  typedef enum logic [2:0] {
    KONG_STAND,
    KONG_WALK_LEFT,
    KONG_WALK_RIGHT,
    KONG_CLIMB_LEFT,
    KONG_CLIMB_RIGHT,
    KONG_JUMP_LEFT,
    KONG_JUMP_RIGHT
  } kong_icon;

  typedef enum logic {
    KONG_LOOK_LEFT,
    KONG_LOOK_RIGHT
  } kong_dir;

  localparam int E_LEFT   = 3;
  localparam int E_TOP    = 2;
  localparam int E_RIGHT  = 1;
  localparam int E_BOTTOM = 0;
endpackage

module kong_controller
  import kong_pkg::*;
#(
  parameter location INIT_X       = 11'sd32,
  parameter location INIT_Y       = 11'sd400,
  parameter int      WALK_SPEED   = 2,
  parameter int      CLIMB_SPEED  = 1,
  parameter int      JUMP_SPEED   = 8,
  parameter int      GRAVITY      = 1,
  parameter int      MAX_FALL     = 8,
  parameter int      SCREEN_WIDTH = 640,
  parameter int      KONG_WIDTH   = 64,
  parameter int      SCREEN_HIGHT = 480,
  parameter int      KONG_HIGHT   = 32
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_jump,
  input  logic [3:0] edges,
  input  logic       rope_hit,
  output location    topLeftX,
  output location    topLeftY,
  output kong_icon   icon,
  output kong_state  state
);

  // Position math runs 12 bits wide so clamping happens before truncation to 11 bits.
  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_WIDTH - KONG_WIDTH);
  localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_HIGHT - KONG_HIGHT);
  localparam logic signed [11:0] C_WALK   = 12'(WALK_SPEED);
  localparam logic signed [11:0] C_CLIMB  = 12'(CLIMB_SPEED);
  localparam logic signed [5:0]  C_WALK_V = 6'(WALK_SPEED);
  localparam logic signed [5:0]  C_JUMP_V = 6'(JUMP_SPEED);
  localparam logic signed [5:0]  C_GRAV_V = 6'(GRAVITY);
  localparam logic signed [5:0]  C_MAXF_V = 6'(MAX_FALL);

  kong_state          r_state, w_state_nxt;
  kong_icon           r_icon,  w_icon_nxt;
  kong_dir            r_dir,   w_dir_nxt;
  location            r_x,     w_x_nxt;
  location            r_y,     w_y_nxt;
  logic signed [5:0]  r_vx,    w_vx_nxt;
  logic signed [5:0]  r_vy,    w_vy_nxt;

  logic signed [11:0] w_x_wide;
  logic signed [11:0] w_y_wide;
  logic signed [11:0] w_step;
  logic signed [5:0]  w_vy_sum;
  logic               w_apply_x;
  logic               w_walk_l;
  logic               w_walk_r;
  logic               w_bottom;

  function automatic location clamp_pos(input logic signed [11:0] v,
                                        input logic signed [11:0] hi);
    if (v < 12'sd0) return '0;
    else if (v > hi) return hi[10:0];
    else return v[10:0];
  endfunction

  function automatic kong_icon jump_icon(input kong_dir d);
    return (d == KONG_LOOK_LEFT) ? KONG_JUMP_LEFT : KONG_JUMP_RIGHT;
  endfunction

  function automatic kong_icon climb_icon(input kong_dir d);
    return (d == KONG_LOOK_LEFT) ? KONG_CLIMB_LEFT : KONG_CLIMB_RIGHT;
  endfunction

  // Frame-gated state register; reset restores the spawn pose and discards velocity.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= KONG_IS_STANDING;
      r_icon  <= KONG_STAND;
      r_dir   <= KONG_LOOK_RIGHT;
      r_x     <= INIT_X;
      r_y     <= INIT_Y;
      r_vx    <= '0;
      r_vy    <= '0;
    end else if (startOfFrame) begin
      r_state <= w_state_nxt;
      r_icon  <= w_icon_nxt;
      r_dir   <= w_dir_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vx    <= w_vx_nxt;
      r_vy    <= w_vy_nxt;
    end
  end

  // Next-frame motion: state transitions, velocities, then wall blocking and X clamping.
  always_comb begin
    w_state_nxt = r_state;
    w_icon_nxt  = r_icon;
    w_dir_nxt   = r_dir;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vx_nxt    = r_vx;
    w_vy_nxt    = r_vy;
    w_x_wide    = 12'(r_x);
    w_y_wide    = 12'(r_y);
    w_step      = '0;
    w_vy_sum    = '0;
    w_apply_x   = 1'b0;
    w_walk_l    = key_left & ~key_right;
    w_walk_r    = key_right & ~key_left;
    // The screen floor acts like a platform while airborne.
    w_bottom    = edges[E_BOTTOM] | (w_y_wide == Y_MAX);

    case (r_state)
      KONG_IS_STANDING: begin
        w_vx_nxt = '0;
        if (!edges[E_BOTTOM]) begin
          w_state_nxt = KONG_IS_JUMPING;
          w_vy_nxt    = '0;
          w_icon_nxt  = jump_icon(r_dir);
        end else if (key_jump) begin
          w_state_nxt = KONG_IS_JUMPING_IN_PLATFORM;
          w_vy_nxt    = -C_JUMP_V;
          w_icon_nxt  = jump_icon(r_dir);
        end else if (rope_hit & key_up) begin
          w_state_nxt = KONG_IS_CLIMBING;
          w_vy_nxt    = '0;
          w_icon_nxt  = climb_icon(r_dir);
        end else if (w_walk_l) begin
          w_dir_nxt  = KONG_LOOK_LEFT;
          w_icon_nxt = KONG_WALK_LEFT;
          w_vx_nxt   = -C_WALK_V;
          w_step     = -C_WALK;
          w_apply_x  = 1'b1;
        end else if (w_walk_r) begin
          w_dir_nxt  = KONG_LOOK_RIGHT;
          w_icon_nxt = KONG_WALK_RIGHT;
          w_vx_nxt   = C_WALK_V;
          w_step     = C_WALK;
          w_apply_x  = 1'b1;
        end else begin
          w_icon_nxt = KONG_STAND;
        end
      end

      KONG_IS_CLIMBING: begin
        if (key_jump) begin
          w_state_nxt = KONG_IS_JUMPING_FROM_ROPE;
          w_vy_nxt    = -C_JUMP_V;
          w_vx_nxt    = (r_dir == KONG_LOOK_LEFT) ? -C_WALK_V : C_WALK_V;
          w_icon_nxt  = jump_icon(r_dir);
        end else if (!rope_hit) begin
          w_state_nxt = KONG_IS_JUMPING;
          w_vy_nxt    = '0;
          w_vx_nxt    = '0;
          w_icon_nxt  = jump_icon(r_dir);
        end else if (key_up ^ key_down) begin
          // The climb animation alternates facing on every frame Kong actually moves.
          w_y_nxt    = clamp_pos(w_y_wide + (key_up ? -C_CLIMB : C_CLIMB), Y_MAX);
          w_dir_nxt  = (r_dir == KONG_LOOK_LEFT) ? KONG_LOOK_RIGHT : KONG_LOOK_LEFT;
          w_icon_nxt = climb_icon(w_dir_nxt);
        end else begin
          w_icon_nxt = climb_icon(r_dir);
        end
      end

      default: begin
        // Airborne: steer from keys unless launched from a rope, which keeps its vx.
        if (r_state != KONG_IS_JUMPING_FROM_ROPE) begin
          if (w_walk_l) begin
            w_vx_nxt  = -C_WALK_V;
            w_dir_nxt = KONG_LOOK_LEFT;
          end else if (w_walk_r) begin
            w_vx_nxt  = C_WALK_V;
            w_dir_nxt = KONG_LOOK_RIGHT;
          end else begin
            w_vx_nxt  = '0;
          end
        end
        w_step     = 12'(w_vx_nxt);
        w_apply_x  = 1'b1;
        w_icon_nxt = jump_icon(w_dir_nxt);

        if (rope_hit & key_up & (r_state != KONG_IS_JUMPING_FROM_ROPE)) begin
          w_state_nxt = KONG_IS_CLIMBING;
          w_vy_nxt    = '0;
          w_vx_nxt    = '0;
          w_apply_x   = 1'b0;
          w_icon_nxt  = climb_icon(w_dir_nxt);
        end else if (!r_vy[5] && w_bottom) begin
          w_state_nxt = KONG_IS_STANDING;
          w_vy_nxt    = '0;
          w_vx_nxt    = '0;
          w_icon_nxt  = KONG_STAND;
        end else if (r_vy[5] && edges[E_TOP]) begin
          w_vy_nxt = '0;
        end else begin
          w_y_nxt  = clamp_pos(w_y_wide + 12'(r_vy), Y_MAX);
          w_vy_sum = r_vy + C_GRAV_V;
          w_vy_nxt = (w_vy_sum > C_MAXF_V) ? C_MAXF_V : w_vy_sum;
        end
      end
    endcase

    if (w_apply_x) begin
      if (((w_step < 12'sd0) && edges[E_LEFT]) || ((w_step > 12'sd0) && edges[E_RIGHT])) begin
        w_step   = '0;
        w_vx_nxt = '0;
      end
      w_x_nxt = clamp_pos(w_x_wide + w_step, X_MAX);
    end
  end

  assign topLeftX = r_x;
  assign topLeftY = r_y;
  assign icon     = r_icon;
  assign state    = r_state;

endmodule

// File: tb/tb_kong_controller.sv
// Directed bench for kong_controller: walking, jump arc, landing, clamping, rope jumps, reset.
// Latency: each frame() pulses startOfFrame once and returns at the following negedge.
// Backpressure: not applicable; outputs are sampled on the falling edge.

module tb_kong_controller;
  import kong_pkg::*;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       key_left, key_right, key_up, key_down, key_jump;
  logic [3:0] edges;
  logic       rope_hit;
  location    topLeftX, topLeftY, hi_x, hi_y;
  kong_icon   icon, hi_icon;
  kong_state  state, hi_state;

  int n_checks;
  int n_errors;

  kong_controller u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_jump(key_jump), .edges(edges),
    .rope_hit(rope_hit), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .icon(icon), .state(state)
  );

  // Second instance spawned next to the right screen limit.
  kong_controller #(.INIT_X(11'sd575)) u_dut_hi (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_jump(key_jump), .edges(edges),
    .rope_hit(rope_hit), .topLeftX(hi_x), .topLeftY(hi_y),
    .icon(hi_icon), .state(hi_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic set_keys(input logic l, input logic r, input logic u,
                          input logic d, input logic j);
    key_left = l; key_right = r; key_up = u; key_down = d; key_jump = j;
  endtask

  int exp_y_up[8]    = '{392, 385, 379, 374, 370, 367, 365, 364};
  int exp_y_down[9]  = '{364, 365, 367, 370, 374, 379, 385, 392, 400};

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    set_keys(0, 0, 0, 0, 0);
    edges = 4'b0000;
    rope_hit = 1'b0;

    // Reset state while reset is held
    #12;
    check("rst_x", int'(topLeftX), 32);
    check("rst_y", int'(topLeftY), 400);
    check("rst_state", int'(state), int'(KONG_IS_STANDING));
    check("rst_icon", int'(icon), int'(KONG_STAND));
    @(negedge clk);
    resetN = 1'b1;

    // Walk right three frames
    edges = 4'b0001;
    set_keys(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("walk_r_x", int'(topLeftX), 34 + 2 * i);
    end
    check("walk_r_y", int'(topLeftY), 400);
    check("walk_r_icon", int'(icon), int'(KONG_WALK_RIGHT));
    check("walk_r_state", int'(state), int'(KONG_IS_STANDING));

    // No frame pulse for 1000 cycles: nothing moves
    edges = 4'b0000;
    set_keys(1, 0, 1, 0, 1);
    rope_hit = 1'b1;
    repeat (1000) @(negedge clk);
    check("hold_x", int'(topLeftX), 38);
    check("hold_y", int'(topLeftY), 400);
    check("hold_icon", int'(icon), int'(KONG_WALK_RIGHT));
    check("hold_state", int'(state), int'(KONG_IS_STANDING));
    rope_hit = 1'b0;

    // Wall blocking both ways, then both keys
    edges = 4'b1001;
    set_keys(1, 0, 0, 0, 0);
    frame();
    check("blk_l_x", int'(topLeftX), 38);
    check("blk_l_icon", int'(icon), int'(KONG_WALK_LEFT));
    edges = 4'b0011;
    set_keys(0, 1, 0, 0, 0);
    frame();
    check("blk_r_x", int'(topLeftX), 38);
    check("blk_r_icon", int'(icon), int'(KONG_WALK_RIGHT));
    edges = 4'b0001;
    set_keys(1, 1, 0, 0, 0);
    frame();
    check("both_x", int'(topLeftX), 38);
    check("both_icon", int'(icon), int'(KONG_STAND));

    // Jump from platform: entry frame keeps Y
    set_keys(0, 0, 0, 0, 1);
    frame();
    check("jmp_entry_y", int'(topLeftY), 400);
    check("jmp_entry_state", int'(state), int'(KONG_IS_JUMPING_IN_PLATFORM));
    check("jmp_entry_icon", int'(icon), int'(KONG_JUMP_RIGHT));
    set_keys(0, 0, 0, 0, 0);
    edges = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      frame();
      check("jmp_up_y", int'(topLeftY), exp_y_up[i]);
    end
    for (int i = 0; i < 9; i++) begin
      frame();
      check("jmp_down_y", int'(topLeftY), exp_y_down[i]);
    end
    check("jmp_x", int'(topLeftX), 38);
    // Landing at full fall speed
    edges = 4'b0001;
    frame();
    check("land_state", int'(state), int'(KONG_IS_STANDING));
    check("land_y", int'(topLeftY), 400);
    check("land_icon", int'(icon), int'(KONG_STAND));

    // Ceiling hit kills upward speed without motion
    set_keys(0, 0, 0, 0, 1);
    frame();
    set_keys(0, 0, 0, 0, 0);
    edges = 4'b0100;
    frame();
    check("ceil_y", int'(topLeftY), 400);
    edges = 4'b0000;
    frame();
    check("ceil_y1", int'(topLeftY), 400);
    frame();
    check("ceil_y2", int'(topLeftY), 401);

    // Reset mid-jump
    #2 resetN = 1'b0;
    #1;
    check("mrst_x", int'(topLeftX), 32);
    check("mrst_y", int'(topLeftY), 400);
    check("mrst_state", int'(state), int'(KONG_IS_STANDING));
    check("mrst_icon", int'(icon), int'(KONG_STAND));
    @(negedge clk);
    resetN = 1'b1;
    edges = 4'b0001;
    frame();
    check("post_rst_y", int'(topLeftY), 400);
    check("post_rst_state", int'(state), int'(KONG_IS_STANDING));
    check("hi_init_x", int'(hi_x), 575);

    // Right screen clamp on the second instance
    set_keys(0, 1, 0, 0, 0);
    frame();
    check("clamp_x1", int'(hi_x), 576);
    frame();
    check("clamp_x2", int'(hi_x), 576);
    check("clamp_icon", int'(hi_icon), int'(KONG_WALK_RIGHT));

    // Rope: face left, grab rope, climb with toggling icon
    set_keys(1, 0, 0, 0, 0);
    frame();
    check("rope_pre_x", int'(topLeftX), 34);
    set_keys(0, 0, 1, 0, 0);
    rope_hit = 1'b1;
    frame();
    check("climb_state", int'(state), int'(KONG_IS_CLIMBING));
    check("climb_icon0", int'(icon), int'(KONG_CLIMB_LEFT));
    check("climb_y0", int'(topLeftY), 400);
    frame();
    check("climb_y1", int'(topLeftY), 399);
    check("climb_icon1", int'(icon), int'(KONG_CLIMB_RIGHT));
    frame();
    check("climb_y2", int'(topLeftY), 398);
    check("climb_icon2", int'(icon), int'(KONG_CLIMB_LEFT));

    // Jump off the rope facing left
    set_keys(0, 0, 0, 0, 1);
    edges = 4'b0000;
    frame();
    check("rj_state", int'(state), int'(KONG_IS_JUMPING_FROM_ROPE));
    check("rj_y0", int'(topLeftY), 398);
    check("rj_icon", int'(icon), int'(KONG_JUMP_LEFT));
    set_keys(0, 0, 1, 0, 0);
    frame();
    check("rj_x1", int'(topLeftX), 32);
    check("rj_y1", int'(topLeftY), 390);
    check("rj_state1", int'(state), int'(KONG_IS_JUMPING_FROM_ROPE));
    set_keys(0, 1, 1, 0, 0);
    frame();
    check("rj_x2", int'(topLeftX), 30);
    check("rj_y2", int'(topLeftY), 383);
    // Floor contact while still rising does not land
    edges = 4'b0001;
    frame();
    check("rj_rise_state", int'(state), int'(KONG_IS_JUMPING_FROM_ROPE));
    check("rj_rise_y", int'(topLeftY), 377);
    check("rj_rise_x", int'(topLeftX), 28);
    edges = 4'b0000;
    repeat (5) frame();
    check("rj_peak_y", int'(topLeftY), 362);
    check("rj_peak_x", int'(topLeftX), 18);
    check("rj_peak_state", int'(state), int'(KONG_IS_JUMPING_FROM_ROPE));
    edges = 4'b0001;
    frame();
    check("rj_land_state", int'(state), int'(KONG_IS_STANDING));
    check("rj_land_y", int'(topLeftY), 362);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
